// File: rtl/decn_scan_pkg.sv
// Shared definitions for the decn_scan registered decoder / auto-scanner.
//   MODE_DIRECT / MODE_SCAN : encodings of the i_mode input
//   state_t                 : control state (IDLE, DIRECT, SCAN)
package decn_scan_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

endpackage : decn_scan_pkg

// File: rtl/decn_scan_scan_prescaler.sv
// Modulo-DIV dwell counter for the scan index.
//   i_clk   : system clock, rising edge
//   i_rstn  : asynchronous active-low reset (count -> 0)
//   i_clr   : synchronous clear (count -> 0), has priority over i_en
//   i_en    : count enable
//   o_tick  : high in the cycle the count sits at DIV-1 while enabled,
//             i.e. the edge that ends the current dwell
module scan_prescaler #(
    parameter int DIV = 4
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    // A single-bit counter is kept even for DIV == 1 so the width is legal.
    localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;

    assign o_tick = i_en & (cnt_r == LAST);

    // Next count: clear wins, otherwise wrap at LAST while enabled.
    always_comb begin
        cnt_s = cnt_r;
        if (i_clr) begin
            cnt_s = {CW{1'b0}};
        end else if (i_en) begin
            if (cnt_r == LAST) begin
                cnt_s = {CW{1'b0}};
            end else begin
                cnt_s = cnt_r + CW'(1);
            end
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Count register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_s;
        end
    end

endmodule : scan_prescaler

// File: rtl/decn_scan.sv
// Registered N-to-2^N one-hot decoder with enable and auto-scan mode.
//   i_clk  : system clock, rising edge
//   i_rstn : asynchronous active-low reset
//   i_en   : enable; low forces o_out to zero (o_idx holds)
//   i_mode : 0 = direct decode of i_in, 1 = auto-scan starting at i_in
//   i_in   : code to decode / scan start index
//   o_out  : registered one-hot output or all-zero
//   o_idx  : registered index currently decoded
//   o_wrap : one-cycle pulse on the edge the scan index goes OUT_W-1 -> 0
module decn_scan
    import decn_scan_pkg::*;
#(
    parameter int IN_W     = 2,
    parameter int SCAN_DIV = 4,
    parameter int OUT_W    = 2 ** IN_W
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_en,
    input  logic             i_mode,
    input  logic [IN_W-1:0]  i_in,
    output logic [OUT_W-1:0] o_out,
    output logic [IN_W-1:0]  o_idx,
    output logic             o_wrap
);

    localparam logic [IN_W-1:0] IDX_MAX = {IN_W{1'b1}};

    function automatic logic [OUT_W-1:0] decode(input logic [IN_W-1:0] idx);
        decode = OUT_W'(1) << idx;
    endfunction

    state_t            state_r;
    state_t            state_s;
    logic [IN_W-1:0]   idx_r;
    logic [IN_W-1:0]   idx_s;
    logic [OUT_W-1:0]  out_r;
    logic [OUT_W-1:0]  out_s;
    logic              wrap_r;
    logic              wrap_s;
    logic              scan_hold_s;
    logic              pre_clr_s;
    logic              tick_s;

    // Steady scan means we were scanning and stay scanning; only then does
    // the dwell counter run. Entry and exit both restart it from zero.
    assign scan_hold_s = (state_r == SCAN) && (state_s == SCAN);
    assign pre_clr_s   = !scan_hold_s;

    scan_prescaler #(
        .DIV (SCAN_DIV)
    ) u_prescaler (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_clr  (pre_clr_s),
        .i_en   (scan_hold_s),
        .o_tick (tick_s)
    );

    // Next state depends only on the current enable/mode inputs.
    always_comb begin
        state_s = IDLE;
        if (!i_en) begin
            state_s = IDLE;
        end else if (i_mode == MODE_SCAN) begin
            state_s = SCAN;
        end else begin
            state_s = DIRECT;
        end
    end

    // Next index, output and wrap; out is always derived from the index so it
    // can never be multi-hot.
    always_comb begin
        idx_s  = idx_r;
        out_s  = {OUT_W{1'b0}};
        wrap_s = 1'b0;
        case (state_s)
            IDLE: begin
                idx_s = idx_r;
                out_s = {OUT_W{1'b0}};
            end
            DIRECT: begin
                idx_s = i_in;
                out_s = decode(i_in);
            end
            SCAN: begin
                if (state_r != SCAN) begin
                    idx_s = i_in;
                end else if (tick_s) begin
                    idx_s  = idx_r + IN_W'(1);
                    wrap_s = (idx_r == IDX_MAX);
                end else begin
                    idx_s = idx_r;
                end
                out_s = decode(idx_s);
            end
            default: begin
                idx_s = idx_r;
                out_s = {OUT_W{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r <= IDLE;
            idx_r   <= {IN_W{1'b0}};
            out_r   <= {OUT_W{1'b0}};
            wrap_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            out_r   <= out_s;
            wrap_r  <= wrap_s;
        end
    end

    assign o_out  = out_r;
    assign o_idx  = idx_r;
    assign o_wrap = wrap_r;

endmodule : decn_scan
